// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle-latency imem reads and
// buffers {pc, instr} pairs in a 2-entry fall-through queue ahead of decode.
module fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  flush_o
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [DATA_WIDTH-1:0] pc_f, inflight_pc;
  logic                  inflight;
  logic [1:0]            count, next_count;
  entry_t                q [2];
  entry_t                in_e, head;
  logic                  push, pop, valid, issue, wr_idx, wr_en;
  logic                  unused_lsbs;

  assign unused_lsbs = ^redirect_pc_i[1:0];

  // An arriving response is visible at the head the same cycle when the queue is
  // empty, so a fresh fetch reaches decode one cycle after its request.
  always_comb begin
    in_e       = '{pc: inflight_pc, instr: imem_rdata_i};
    push       = inflight & ~redirect_i;
    valid      = (count != 2'd0) | push;
    head       = (count != 2'd0) ? q[0] : in_e;
    pop        = valid & ~stall_i & ~redirect_i;
    next_count = count + {1'b0, push} - {1'b0, pop};
    issue      = ~redirect_i & (next_count < 2'd2);
    wr_en      = push & ~((count == 2'd0) & pop);
    wr_idx     = (count == 2'd1) & ~pop;
  end

  assign imem_req_o  = ~rst & issue;
  assign imem_addr_o = pc_f;
  assign valid_o     = valid;
  assign instr_o     = valid ? head.instr : NOP;
  assign pc_o        = valid ? head.pc : '0;
  assign pc_plus4_o  = valid ? head.pc + DATA_WIDTH'(4) : '0;
  assign flush_o     = redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f        <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      q[0]        <= '0;
      q[1]        <= '0;
    end else if (redirect_i) begin
      pc_f     <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      count <= next_count;
      if (pop && count == 2'd2) q[0] <= q[1];
      if (wr_en) q[wr_idx] <= in_e;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_f;
        pc_f        <= pc_f + DATA_WIDTH'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table from reset, async-reset sequence,
// then randomized stall/redirect traffic against a queue-level reference model.
module tb_fetch_unit;
  localparam logic [31:0] RV  = 32'hBFC00000;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0, rst = 1'b1, stall_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o, valid_o, flush_o;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, pc_plus4_o;
  logic [31:0] key = '0;
  int          n_pass = 0, n_total = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o), .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word content is its address xor key.
  always @(posedge clk) imem_rdata_i <= imem_req_o ? (imem_addr_o ^ key) : 32'hDEADBEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_outs(input string tag, input bit ev, input logic [31:0] epc,
                            input bit ereq, input logic [31:0] eaddr, input bit eflush);
    check({tag, ".valid"}, 32'(valid_o), 32'(ev));
    check({tag, ".pc"},    pc_o,       ev ? epc : 32'h0);
    check({tag, ".pc4"},   pc_plus4_o, ev ? epc + 32'd4 : 32'h0);
    check({tag, ".instr"}, instr_o,    ev ? (epc ^ key) : NOP);
    check({tag, ".req"},   32'(imem_req_o), 32'(ereq));
    if (ereq) check({tag, ".addr"}, imem_addr_o, eaddr);
    check({tag, ".flush"}, 32'(flush_o), 32'(eflush));
  endtask

  typedef struct {
    bit stall; bit redir; logic [31:0] rpc;
    bit ev; logic [31:0] epc; bit ereq; logic [31:0] eaddr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit s, bit r, logic [31:0] rpc, bit ev, logic [31:0] epc,
                              bit ereq, logic [31:0] eaddr);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rpc; v.ev = ev; v.epc = epc; v.ereq = ereq; v.eaddr = eaddr;
    return v;
  endfunction

  // Reference model: fetch address, one outstanding read, list of buffered pcs.
  logic [31:0] m_pcf, m_ipc;
  bit          m_infl;
  logic [31:0] m_q[$];

  task automatic model_reset();
    m_pcf = RV; m_infl = 0; m_ipc = '0; m_q.delete();
  endtask

  task automatic step(input bit s, input bit r, input logic [31:0] rpc);
    logic [31:0] lst[$];
    logic [31:0] hpc;
    bit          pop, req;
    int          nl;
    stall_i = s; redirect_i = r; redirect_pc_i = rpc;
    #1;
    lst = m_q;
    if (m_infl && !r) lst.push_back(m_ipc);
    pop = (lst.size() > 0) && !s && !r;
    nl  = lst.size() - (pop ? 1 : 0);
    req = !r && nl < 2;
    hpc = (lst.size() > 0) ? lst[0] : 32'h0;
    check_outs("rand", lst.size() > 0, hpc, req, m_pcf, r);
    if (r) begin
      m_q.delete(); m_infl = 0; m_pcf = rpc & ~32'h3;
    end else begin
      if (pop) void'(lst.pop_front());
      m_q = lst;
      m_infl = req;
      if (req) begin m_ipc = m_pcf; m_pcf = m_pcf + 32'd4; end
    end
    @(negedge clk);
  endtask

  initial begin
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, RV));
    tbl.push_back(mk(0, 0, 0,            1, RV,           1, RV + 4));
    tbl.push_back(mk(0, 0, 0,            1, RV + 4,       1, RV + 8));
    tbl.push_back(mk(1, 0, 0,            1, RV + 8,       1, RV + 12));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 0,          1, RV + 8,       0, RV + 16));
    tbl.push_back(mk(0, 0, 0,            1, RV + 8,       1, RV + 16));
    tbl.push_back(mk(0, 0, 0,            1, RV + 12,      1, RV + 20));
    tbl.push_back(mk(0, 0, 0,            1, RV + 16,      1, RV + 24));
    tbl.push_back(mk(1, 0, 0,            1, RV + 20,      0, RV + 28));
    tbl.push_back(mk(0, 1, 32'h100,      1, RV + 20,      0, RV + 28));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 32'h100));
    tbl.push_back(mk(0, 0, 0,            1, 32'h100,      1, 32'h104));
    tbl.push_back(mk(1, 1, 32'h102,      0, 0,            0, 32'h108));
    tbl.push_back(mk(1, 0, 0,            0, 0,            1, 32'h100));
    tbl.push_back(mk(0, 0, 0,            1, 32'h100,      1, 32'h104));
    tbl.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 0,            0, 32'h108));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 32'hFFFFFFFC));
    tbl.push_back(mk(0, 0, 0,            1, 32'hFFFFFFFC, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0,            1, 32'h0,        1, 32'h4));

    // Reset state with the clock running.
    repeat (3) @(negedge clk);
    #1 check_outs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      stall_i = tbl[i].stall; redirect_i = tbl[i].redir; redirect_pc_i = tbl[i].rpc;
      #1 check_outs($sformatf("vec%0d", i + 1), tbl[i].ev, tbl[i].epc, tbl[i].ereq,
                    tbl[i].eaddr, tbl[i].redir);
      @(negedge clk);
    end

    // Reset asserted between clock edges mid-stream takes effect immediately.
    stall_i = 0; redirect_i = 0;
    #2 rst = 1'b1;
    #1 check_outs("midrst", 0, 0, 0, 0, 0);
    @(negedge clk);
    key = 32'h5A5AC3C3;
    rst = 1'b0;
    model_reset();
    repeat (3) step(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      bit          s, r;
      logic [31:0] rpc;
      s   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(s, r, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
